// File: rtl/lcd_text_ctrl_if.sv
// Bus between the clock/alarm datapath (master) and the character LCD controller (slave).
// With LCD_CURSOR_EN defined the bus also carries the cursor position and enable.
interface lcd_text_ctrl_if #(
    parameter int COLS  = 16,
    parameter int LINES = 2
);
    logic [LINES*COLS*8-1:0] charBuf_i;
    logic                    refresh_i;
`ifdef LCD_CURSOR_EN
    logic [1:0]              cursorLine_i;
    logic [4:0]              cursorCol_i;
    logic [0:0]              cursorOn_i;
`endif
    logic                    ready_o;
    logic                    busy_o;
    logic                    frameDone_o;
    logic                    lcdRs_o;
    logic                    lcdRw_o;
    logic                    lcdE_o;
    logic [7:0]              lcdData_o;

`ifdef LCD_CURSOR_EN
    modport master (
        output charBuf_i, refresh_i, cursorLine_i, cursorCol_i, cursorOn_i,
        input  ready_o, busy_o, frameDone_o, lcdRs_o, lcdRw_o, lcdE_o, lcdData_o
    );
    modport slave (
        input  charBuf_i, refresh_i, cursorLine_i, cursorCol_i, cursorOn_i,
        output ready_o, busy_o, frameDone_o, lcdRs_o, lcdRw_o, lcdE_o, lcdData_o
    );
`else
    modport master (
        output charBuf_i, refresh_i,
        input  ready_o, busy_o, frameDone_o, lcdRs_o, lcdRw_o, lcdE_o, lcdData_o
    );
    modport slave (
        input  charBuf_i, refresh_i,
        output ready_o, busy_o, frameDone_o, lcdRs_o, lcdRw_o, lcdE_o, lcdData_o
    );
`endif
endinterface

// File: rtl/lcd_text_ctrl.sv
// HD44780-class LCD controller: power-up init, then LINES x COLS frames from a snapshot of the buffer.
// Optional macro LCD_CURSOR_EN: display-control refresh and a cursor address slot in every frame.
module lcd_text_ctrl #(
    parameter int COLS         = 16,
    parameter int LINES        = 2,
    parameter int INIT_WAIT    = 70,
    parameter int WRITE_CYC    = 20,
    parameter int E_HIGH       = 8,
    parameter int CLEAR_WAIT   = 400,
    parameter int AUTO_REFRESH = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    lcd_text_ctrl_if.slave bus
);
    localparam int MAX_WAIT = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int MAX_CNT  = (MAX_WAIT > WRITE_CYC) ? MAX_WAIT : WRITE_CYC;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int BUF_W    = LINES * COLS * 8;
    localparam logic [7:0] FUNC_CMD = (LINES == 1) ? 8'h30 : 8'h38;

    typedef enum logic [3:0] {
        POWER_WAIT, FUNC_SET, DISP_CTRL, ENTRY_MODE, CLEAR, CLEAR_HOLD,
        IDLE, SET_ADDR, WRITE_CHAR, CURSOR_ADDR
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       col_q;
    logic [1:0]       line_q;
    logic [BUF_W-1:0] buf_q;
    logic             pending_q;
    logic             ready_q;
    logic             busy_q;
    logic             frameDone_q;
    logic             lcdRs_q;
    logic             lcdE_q;
    logic [7:0]       lcdData_q;

    logic             slotState;
    logic             slotEnd;
    logic             startFrame;
    logic [7:0]       dispCmd;

    function automatic logic [6:0] lineBase(input logic [1:0] l);
        case (l)
            2'd0:    lineBase = 7'h00;
            2'd1:    lineBase = 7'h40;
            2'd2:    lineBase = 7'h14;
            default: lineBase = 7'h54;
        endcase
    endfunction

`ifdef LCD_CURSOR_EN
    assign dispCmd = bus.cursorOn_i[0] ? 8'h0F : 8'h0C;
`else
    assign dispCmd = 8'h0C;
`endif

    assign slotState  = state_q inside {FUNC_SET, DISP_CTRL, ENTRY_MODE, CLEAR,
                                        SET_ADDR, WRITE_CHAR, CURSOR_ADDR};
    assign slotEnd    = (cnt_q == CNT_W'(WRITE_CYC - 1));
    assign startFrame = (AUTO_REFRESH != 0) || bus.refresh_i || pending_q;

    // Every bus write is one slot: RS/DATA change only on the edge that opens the next slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= POWER_WAIT;
            cnt_q       <= '0;
            col_q       <= '0;
            line_q      <= '0;
            buf_q       <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            lcdRs_q     <= 1'b0;
            lcdE_q      <= 1'b0;
            lcdData_q   <= 8'h00;
        end else begin
            frameDone_q <= 1'b0;
            lcdE_q      <= slotState && (cnt_q < CNT_W'(E_HIGH));
            if (bus.refresh_i && state_q != IDLE) begin
                pending_q <= 1'b1;
            end
            if (slotState) begin
                cnt_q <= slotEnd ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                POWER_WAIT: begin
                    if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
                        state_q   <= FUNC_SET;
                        cnt_q     <= '0;
                        lcdRs_q   <= 1'b0;
                        lcdData_q <= FUNC_CMD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FUNC_SET: if (slotEnd) begin
                    state_q   <= DISP_CTRL;
                    lcdData_q <= dispCmd;
                end
                // Busy distinguishes the per-frame display-control resend from the init one.
                DISP_CTRL: if (slotEnd) begin
                    if (busy_q) begin
                        state_q   <= SET_ADDR;
                        lcdData_q <= 8'h80 | {1'b0, lineBase(2'd0)};
                    end else begin
                        state_q   <= ENTRY_MODE;
                        lcdData_q <= 8'h06;
                    end
                end
                ENTRY_MODE: if (slotEnd) begin
                    state_q   <= CLEAR;
                    lcdData_q <= 8'h01;
                end
                CLEAR: if (slotEnd) begin
                    state_q <= CLEAR_HOLD;
                end
                CLEAR_HOLD: begin
                    if (cnt_q == CNT_W'(CLEAR_WAIT - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: if (startFrame) begin
                    busy_q    <= 1'b1;
                    pending_q <= 1'b0;
                    buf_q     <= bus.charBuf_i;
                    line_q    <= '0;
                    col_q     <= '0;
                    cnt_q     <= '0;
                    lcdRs_q   <= 1'b0;
`ifdef LCD_CURSOR_EN
                    state_q   <= DISP_CTRL;
                    lcdData_q <= dispCmd;
`else
                    state_q   <= SET_ADDR;
                    lcdData_q <= 8'h80 | {1'b0, lineBase(2'd0)};
`endif
                end
                SET_ADDR: if (slotEnd) begin
                    state_q   <= WRITE_CHAR;
                    col_q     <= '0;
                    lcdRs_q   <= 1'b1;
                    lcdData_q <= buf_q[7:0];
                    buf_q     <= buf_q >> 8;
                end
                // The snapshot is consumed by shifting, so characters leave in buffer order.
                WRITE_CHAR: if (slotEnd) begin
                    if (col_q != 5'(COLS - 1)) begin
                        col_q     <= col_q + 5'd1;
                        lcdData_q <= buf_q[7:0];
                        buf_q     <= buf_q >> 8;
                    end else if (line_q != 2'(LINES - 1)) begin
                        line_q    <= line_q + 2'd1;
                        col_q     <= '0;
                        state_q   <= SET_ADDR;
                        lcdRs_q   <= 1'b0;
                        lcdData_q <= 8'h80 | {1'b0, lineBase(line_q + 2'd1)};
                    end else begin
`ifdef LCD_CURSOR_EN
                        state_q   <= CURSOR_ADDR;
                        lcdRs_q   <= 1'b0;
                        lcdData_q <= 8'h80 | {1'b0, lineBase(bus.cursorLine_i) + {2'b00, bus.cursorCol_i}};
`else
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frameDone_q <= 1'b1;
`endif
                    end
                end
                CURSOR_ADDR: if (slotEnd) begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    frameDone_q <= 1'b1;
                end
                default: state_q <= POWER_WAIT;
            endcase
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.frameDone_o = frameDone_q;
    assign bus.lcdRs_o     = lcdRs_q;
    assign bus.lcdRw_o     = 1'b0;
    assign bus.lcdE_o      = lcdE_q;
    assign bus.lcdData_o   = lcdData_q;
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: a request-driven 16x2 panel and a free-running 20x4 panel,
// each checked against a byte-stream model of the panel protocol.
module tb_lcd_text_ctrl;
    localparam int COLS       = 16;
    localparam int LINES      = 2;
    localparam int INIT_WAIT  = 10;
    localparam int WRITE_CYC  = 4;
    localparam int E_HIGH     = 1;
    localparam int CLEAR_WAIT = 20;
    localparam int BUF_W      = LINES * COLS * 8;
    localparam int FRAME_CYC  = LINES * (COLS + 1) * WRITE_CYC;
    localparam int READY_CYC  = INIT_WAIT + 4 * WRITE_CYC + CLEAR_WAIT;
    localparam int B_COLS     = 20;
    localparam int B_LINES    = 4;
    localparam int B_BUF_W    = B_LINES * B_COLS * 8;

    typedef struct {
        logic [BUF_W-1:0] charBuf;
        logic [7:0]       expFirstChar;
        logic [7:0]       expAddr1;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lcd_text_ctrl_if #(.COLS(COLS), .LINES(LINES))     busA ();
    lcd_text_ctrl_if #(.COLS(B_COLS), .LINES(B_LINES)) busB ();

    lcd_text_ctrl #(
        .COLS(COLS), .LINES(LINES), .INIT_WAIT(INIT_WAIT), .WRITE_CYC(WRITE_CYC),
        .E_HIGH(E_HIGH), .CLEAR_WAIT(CLEAR_WAIT), .AUTO_REFRESH(0)
    ) dutA (
        .clk_i(clk), .rst_ni(rstN), .bus(busA)
    );

    lcd_text_ctrl #(
        .COLS(B_COLS), .LINES(B_LINES), .INIT_WAIT(INIT_WAIT), .WRITE_CYC(WRITE_CYC),
        .E_HIGH(E_HIGH), .CLEAR_WAIT(CLEAR_WAIT), .AUTO_REFRESH(1)
    ) dutB (
        .clk_i(clk), .rst_ni(rstN), .bus(busB)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Panel-side view of dutA: one {RS,DATA} word per rising E, plus strobe shape checks.
    logic [8:0] gotQ[$];
    int         frameDones = 0;
    logic       prevE = 1'b0;
    int         eRun = 0;
    logic [8:0] slotWord = '0;

    always @(negedge clk) begin
        if (busA.lcdE_o && !prevE) begin
            slotWord = {busA.lcdRs_o, busA.lcdData_o};
            gotQ.push_back(slotWord);
            checkOutput("rw_low", 32'(busA.lcdRw_o), 32'd0);
        end
        if (busA.lcdE_o) begin
            eRun++;
        end else if (prevE) begin
            checkOutput("e_width", eRun, E_HIGH);
            checkOutput("slot_hold", 32'({busA.lcdRs_o, busA.lcdData_o}), 32'(slotWord));
            eRun = 0;
        end
        if (busA.frameDone_o) frameDones++;
        prevE = busA.lcdE_o;
    end

    // dutB: collect every write of its first frame after READY.
    logic [8:0] gotB[$];
    logic       prevEB = 1'b0;
    logic       bDone = 1'b0;

    always @(negedge clk) begin
        if (rstN && busB.ready_o && !bDone) begin
            if (busB.lcdE_o && !prevEB) gotB.push_back({busB.lcdRs_o, busB.lcdData_o});
            if (busB.frameDone_o) bDone = 1'b1;
        end
        prevEB = busB.lcdE_o;
    end

    // Reference model: the byte stream a panel should receive, built from line/column rules.
    logic [8:0] expQ[$];

    function automatic logic [7:0] baseOf(input int line);
        case (line)
            0:       return 8'h00;
            1:       return 8'h40;
            2:       return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    task automatic modelInit();
        expQ = {};
        expQ.push_back(9'h038);
        expQ.push_back(9'h00C);
        expQ.push_back(9'h006);
        expQ.push_back(9'h001);
    endtask

    task automatic modelFrame(input logic [B_BUF_W-1:0] b, input int cols, input int lines);
        expQ = {};
        for (int l = 0; l < lines; l++) begin
            expQ.push_back({1'b0, 8'h80 | baseOf(l)});
            for (int c = 0; c < cols; c++) expQ.push_back({1'b1, b[8*(l*cols+c) +: 8]});
        end
    endtask

    task automatic compareStream(input string tag, input logic [8:0] got[$]);
        int n;
        checkOutput({tag, "_count"}, got.size(), expQ.size());
        n = (got.size() < expQ.size()) ? got.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(expQ[i]));
    endtask

    function automatic logic [BUF_W-1:0] makeBuf(input string s);
        logic [BUF_W-1:0] r;
        r = {(BUF_W/8){8'h20}};
        for (int i = 0; i < s.len() && i < LINES*COLS; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [BUF_W-1:0] randBuf();
        logic [BUF_W-1:0] r;
        for (int i = 0; i < BUF_W/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic pulseRefresh();
        @(negedge clk);
        busA.refresh_i = 1'b1;
        @(negedge clk);
        busA.refresh_i = 1'b0;
    endtask

    // Load a buffer, request a frame and return the cycle BUSY was first seen.
    task automatic applyStimulus(input logic [BUF_W-1:0] b, output int startCyc);
        int reqCyc;
        @(negedge clk);
        gotQ = {};
        busA.charBuf_i = b;
        busA.refresh_i = 1'b1;
        reqCyc = cyc;
        @(negedge clk);
        busA.refresh_i = 1'b0;
        startCyc = -1;
        for (int i = 0; i < 8 && startCyc < 0; i++) begin
            if (busA.busy_o) startCyc = cyc;
            else @(negedge clk);
        end
        checkOutput("start_latency", startCyc - reqCyc, 1);
    endtask

    task automatic waitFrameEnd(input logic [BUF_W-1:0] expBuf, input int startCyc, input string tag);
        int doneCyc = -1;
        for (int i = 0; i < FRAME_CYC + 50 && doneCyc < 0; i++) begin
            @(negedge clk);
            if (busA.frameDone_o) doneCyc = cyc;
        end
        checkOutput({tag, "_frame_len"}, doneCyc - startCyc, FRAME_CYC);
        checkOutput({tag, "_busy_drop"}, 32'(busA.busy_o), 32'd0);
        modelFrame({{(B_BUF_W-BUF_W){1'b0}}, expBuf}, COLS, LINES);
        compareStream(tag, gotQ);
    endtask

    task automatic waitReady(input int relCyc, input string tag);
        int readyCyc = -1;
        for (int i = 0; i < 300 && readyCyc < 0; i++) begin
            @(negedge clk);
            if (busA.ready_o) readyCyc = cyc;
        end
        checkOutput({tag, "_ready_cycle"}, readyCyc - relCyc, READY_CYC);
        modelInit();
        compareStream({tag, "_cmds"}, gotQ);
        gotQ = {};
    endtask

    function automatic logic [13:0] allOutputsA();
        return {busA.ready_o, busA.busy_o, busA.frameDone_o, busA.lcdRs_o,
                busA.lcdRw_o, busA.lcdE_o, busA.lcdData_o};
    endfunction

    vec_t              vecs[3];
    logic [BUF_W-1:0]  b0, b1;
    logic [B_BUF_W-1:0] bufB;
    logic [8:0]        cmdB[$];
    logic [7:0]        expAddrB[4];
    int                s, rel, doneBase, dataB;

    initial begin
        vecs[0] = '{makeBuf("12:34:56  AM"), 8'h31, 8'hC0};
        vecs[1] = '{makeBuf("ALARM 07:30     WAKE UP"), 8'h41, 8'hC0};
        for (int i = 0; i < LINES*COLS; i++) vecs[1].charBuf[8*i +: 8] = vecs[1].charBuf[8*i +: 8];
        vecs[2].charBuf = '0;
        for (int i = 0; i < LINES*COLS; i++) vecs[2].charBuf[8*i +: 8] = 8'(i);
        vecs[2].expFirstChar = 8'h00;
        vecs[2].expAddr1     = 8'hC0;
        expAddrB = '{8'h80, 8'hC0, 8'h94, 8'hD4};
        for (int i = 0; i < B_LINES*B_COLS; i++) bufB[8*i +: 8] = 8'(i*3 + 7);

        rstN = 1'b0;
        busA.charBuf_i = vecs[0].charBuf;
        busA.refresh_i = 1'b0;
        busB.charBuf_i = bufB;
        busB.refresh_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'(allOutputsA()), 32'd0);

        // Boot, with a request issued before READY that must be held as pending.
        gotQ = {};
        rstN = 1'b1;
        rel  = cyc;
        repeat (3) @(negedge clk);
        busA.refresh_i = 1'b1;
        @(negedge clk);
        busA.refresh_i = 1'b0;
        waitReady(rel, "init");
        @(negedge clk);
        checkOutput("pending_start", 32'(busA.busy_o), 32'd1);
        s = cyc;
        waitFrameEnd(vecs[0].charBuf, s, "pending_frame");

        for (int v = 0; v < 3; v++) begin
            applyStimulus(vecs[v].charBuf, s);
            waitFrameEnd(vecs[v].charBuf, s, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_first_char", v), 32'(gotQ[1]), 32'({1'b1, vecs[v].expFirstChar}));
            checkOutput($sformatf("vec%0d_addr1", v), 32'(gotQ[COLS+1]), 32'({1'b0, vecs[v].expAddr1}));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", v), 32'(busA.frameDone_o), 32'd0);
        end

        for (int k = 0; k < 4; k++) begin
            b0 = randBuf();
            applyStimulus(b0, s);
            waitFrameEnd(b0, s, $sformatf("rand%0d", k));
        end

        // Buffer changes mid-frame must not tear the frame in flight.
        b0 = randBuf();
        b1 = randBuf();
        applyStimulus(b0, s);
        while (cyc < s + 50) @(negedge clk);
        busA.charBuf_i = b1;
        waitFrameEnd(b0, s, "tear_old");
        applyStimulus(b1, s);
        waitFrameEnd(b1, s, "tear_new");

        // Three requests while busy collapse into exactly one extra frame.
        b0 = randBuf();
        applyStimulus(b0, s);
        doneBase = frameDones;
        for (int p = 0; p < 3; p++) begin
            repeat (15) @(negedge clk);
            pulseRefresh();
        end
        waitFrameEnd(b0, s, "multi_first");
        gotQ = {};
        @(negedge clk);
        checkOutput("multi_restart", 32'(busA.busy_o), 32'd1);
        checkOutput("multi_done_pulse", 32'(busA.frameDone_o), 32'd0);
        s = cyc;
        waitFrameEnd(b0, s, "multi_second");
        repeat (FRAME_CYC + 20) @(negedge clk);
        checkOutput("multi_frames", frameDones - doneBase, 2);
        checkOutput("multi_idle", 32'(busA.busy_o), 32'd0);

        // Asynchronous reset at slot 20 with a request pending; the request must be dropped.
        b0 = randBuf();
        applyStimulus(b0, s);
        repeat (10) @(negedge clk);
        pulseRefresh();
        while (cyc < s + 20*WRITE_CYC) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busA.busy_o), 32'd1);
        #2 rstN = 1'b0;
        #1 checkOutput("async_reset", 32'(allOutputsA()), 32'd0);
        @(negedge clk);
        gotQ = {};
        rstN = 1'b1;
        rel  = cyc;
        waitReady(rel, "reinit");
        repeat (20) @(negedge clk);
        checkOutput("pending_cleared", 32'(busA.busy_o), 32'd0);
        applyStimulus(vecs[1].charBuf, s);
        waitFrameEnd(vecs[1].charBuf, s, "post_reset");

        // Free-running 20x4 panel: first frame's stream and line addresses.
        checkOutput("b_frame_seen", 32'(bDone), 32'd1);
        modelFrame(bufB, B_COLS, B_LINES);
        compareStream("b_frame", gotB);
        cmdB  = {};
        dataB = 0;
        foreach (gotB[i]) begin
            if (gotB[i][8]) dataB++;
            else cmdB.push_back(gotB[i]);
        end
        checkOutput("b_addr_count", cmdB.size(), 4);
        checkOutput("b_data_count", dataB, B_LINES*B_COLS);
        for (int i = 0; i < 4 && i < cmdB.size(); i++)
            checkOutput($sformatf("b_addr%0d", i), 32'(cmdB[i]), 32'({1'b0, expAddrB[i]}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
